// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared unit IDs and entry sizing for the ALU result path
package alu_pkg;

  localparam int WIDTH_DEFAULT = 16;

  localparam logic [1:0] UNIT_ARITH = 2'd0;
  localparam logic [1:0] UNIT_LOGIC = 2'd1;
  localparam logic [1:0] UNIT_CMP   = 2'd2;
  localparam logic [1:0] UNIT_SHIFT = 2'd3;

  // Entry layout is {unit[1:0], result[2*WIDTH-1:0], carry}
  localparam int ENTRY_W = 2 * WIDTH_DEFAULT + 3;

  function automatic int entry_width(input int width);
    return 2 * width + 3;
  endfunction

endpackage

// File: rtl/alu_result_fifo.sv
// rtl/alu_result_fifo.sv - show-ahead synchronous FIFO for tagged ALU results
module alu_result_fifo
  import alu_pkg::*;
#(
  parameter int DATA_W = ENTRY_W,
  parameter int DEPTH  = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [DATA_W-1:0]        din,
  output logic [DATA_W-1:0]        dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic              pop_ok;
  logic              push_ok;

  assign empty   = (count == '0);
  assign full    = (count == FULL_CNT);
  assign pop_ok  = pop && !empty;
  // A full FIFO can still take a push when the head leaves on the same edge
  assign push_ok = push && (!full || pop_ok);

  // Head is presented directly; zero when nothing is buffered
  assign dout = empty ? '0 : mem[rd_ptr];

  // Storage write; contents are don't-care until the count covers them
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= din;
  end

  // Pointer and occupancy tracking, pointers wrap naturally (DEPTH is 2^AW)
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/alu_result_collector.sv
// rtl/alu_result_collector.sv - tags ALU unit results, buffers them and tracks drop/conflict status
module alu_result_collector
  import alu_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT,
  parameter int DEPTH = 4,
  parameter int CNT_W = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [2*WIDTH-1:0]      arith_out,
  input  logic                    carry_out,
  input  logic                    arith_flag,
  input  logic [2*WIDTH-1:0]      logic_out,
  input  logic                    logic_flag,
  input  logic [2*WIDTH-1:0]      cmp_out,
  input  logic                    cmp_flag,
  input  logic [2*WIDTH-1:0]      shift_out,
  input  logic                    shift_flag,
  input  logic                    clr_status,
  output logic                    res_valid,
  input  logic                    res_ready,
  output logic [2*WIDTH-1:0]      res_data,
  output logic [1:0]              res_unit,
  output logic                    res_carry,
  output logic [$clog2(DEPTH):0]  fifo_count,
  output logic                    conflict_err,
  output logic                    overflow_err,
  output logic [CNT_W-1:0]        drop_cnt
);

  localparam int EW = entry_width(WIDTH);

  logic [3:0]         flags;
  logic               single;
  logic               multi;
  logic [1:0]         sel_unit;
  logic [2*WIDTH-1:0] sel_data;
  logic               sel_carry;
  logic [EW-1:0]      entry;
  logic [EW-1:0]      head;
  logic               full;
  logic               empty;
  logic               pop;
  logic               drop;

  assign flags = {shift_flag, cmp_flag, logic_flag, arith_flag};

  // Classify the flag pattern: one result, a conflict, or idle
  always_comb begin
    single = $onehot(flags);
    multi  = ($countones(flags) > 1);
  end

  // Select the producing unit's result; carry only travels with arithmetic
  always_comb begin
    sel_unit  = UNIT_ARITH;
    sel_data  = arith_out;
    sel_carry = carry_out;
    if (logic_flag) begin
      sel_unit  = UNIT_LOGIC;
      sel_data  = logic_out;
      sel_carry = 1'b0;
    end else if (cmp_flag) begin
      sel_unit  = UNIT_CMP;
      sel_data  = cmp_out;
      sel_carry = 1'b0;
    end else if (shift_flag) begin
      sel_unit  = UNIT_SHIFT;
      sel_data  = shift_out;
      sel_carry = 1'b0;
    end
  end

  assign entry = {sel_unit, sel_data, sel_carry};
  assign pop   = res_valid && res_ready;
  assign drop  = single && full && !pop;

  alu_result_fifo #(
    .DATA_W (EW),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (single),
    .pop   (pop),
    .din   (entry),
    .dout  (head),
    .full  (full),
    .empty (empty),
    .count (fifo_count)
  );

  assign res_valid = !empty;
  assign {res_unit, res_data, res_carry} = head;

  // Sticky status; a clear wins over any set landing on the same edge
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      conflict_err <= 1'b0;
      overflow_err <= 1'b0;
      drop_cnt     <= '0;
    end else if (clr_status) begin
      conflict_err <= 1'b0;
      overflow_err <= 1'b0;
      drop_cnt     <= '0;
    end else begin
      if (multi) conflict_err <= 1'b1;
      if (drop) begin
        overflow_err <= 1'b1;
        if (drop_cnt != {CNT_W{1'b1}}) drop_cnt <= drop_cnt + 1'b1;
      end
    end
  end

endmodule
